cpucore_rd_arb: RTL and testbench
=================================

CPUCORE_RD_ARB -- requirements
Module: cpucore_rd_arb

Interface
REQ-001 SHALL have parameter MAX_OUTSTD, default 4, giving the maximum outstanding read bursts per master (range 1..15).
REQ-002 SHALL have port ref_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports m0_/m1_ ARADDR, input, 32 bits: upstream read address.
REQ-005 SHALL have ports m0_/m1_ ARID, input, 7 bits: upstream read ID.
REQ-006 SHALL have ports m0_/m1_ ARLEN and ARSIZE, input, 4 bits each: burst length and beat size.
REQ-007 SHALL have ports m0_/m1_ ARVALID (input) and ARREADY (output), 1 bit each: upstream address handshake.
REQ-008 SHALL have ports m0_/m1_ RID (output, 7), RDATA (output, 128), RRESP (output, 2), RLAST (output, 1), RVALID (output, 1) and RREADY (input, 1): upstream read data.
REQ-009 SHALL have ports cpucore_mst_ARADDR, ARID (8 bits), ARLEN, ARSIZE, ARVALID as outputs and ARREADY as input: downstream address channel.
REQ-010 SHALL have ports cpucore_mst_RID (8), RDATA (128), RRESP (2), RLAST and RVALID as inputs and RREADY as output: downstream data channel.
REQ-011 SHALL have port error_fiq, output, 1 bit: sticky routing-error flag.

Function
REQ-012 SHALL use a 2-state FSM: IDLE -> ISSUE when a master is granted; ISSUE -> IDLE on cpucore_mst_ARVALID & ARREADY.
REQ-013 SHALL treat a master as eligible in IDLE when its ARVALID=1 and its outstanding count is below MAX_OUTSTD.
REQ-014 SHALL, in IDLE, assert mX_ARREADY combinationally for exactly the granted master, and register ARADDR/ARLEN/ARSIZE and ARID={X,mX_ARID} in that same cycle.
REQ-015 SHALL grant round-robin: a single eligible master wins; when both are eligible, the master not granted last wins.
REQ-016 SHALL hold cpucore_mst_ARVALID=1 and the payload stable throughout ISSUE, with no upstream ARREADY asserted during ISSUE.
REQ-017 SHALL give a peak AR throughput of one burst every 2 cycles, and a latency of 1 cycle from the upstream handshake to downstream ARVALID.
REQ-018 SHALL route R combinationally on cpucore_mst_RID[7]: the selected mX_RVALID equals RVALID, RID equals RID[6:0], and cpucore_mst_RREADY equals the selected mX_RREADY.
REQ-019 SHALL increment a per-master outstanding counter on the upstream AR handshake and decrement it on R handshake with RLAST.
REQ-020 SHALL leave a counter unchanged when its increment and decrement occur in the same cycle.
REQ-021 SHALL, when RVALID arrives for a master whose count is 0, set error_fiq=1, sink the beat (RREADY=1, upstream RVALID=0), and hold error_fiq until reset.
REQ-022 SHALL block a master at count=MAX_OUTSTD from grant without affecting the other master.

Reset
REQ-023 SHALL on sys_rst set state=IDLE, both counters=0, last-grant=m1 (so m0 wins the first tie), error_fiq=0 and cpucore_mst_ARVALID=0.
REQ-024 SHALL let sys_rst asserted mid-ISSUE drop ARVALID on the next edge and discard the captured request; the downstream is reset on the same reset.

Configuration
REQ-025 SHALL, with CPUCORE_RD_ARB_PERF_EN defined, add outputs m0_gnt_cnt and m1_gnt_cnt (16 bits each, saturating at 0xFFFF, incremented per grant, reset to 0).
REQ-026 SHALL, without CPUCORE_RD_ARB_PERF_EN, omit those ports and their logic entirely.

Structure
REQ-027 SHALL take the AXI width constants (ADDR_W=32, ID_W=8, DATA_W=128, LEN_W=4) and the FSM state enum from shared package cpucore_axi_pkg.
REQ-028 SHALL implement the round-robin decision in one sub-module, rr_arb2 (req[1:0], last, gnt[1:0]), which is purely combinational.

Verification
REQ-029 SHALL cover: m0 alone ARADDR=0x1000, ARID=0x05 -> downstream ARID=0x05, ARVALID one cycle after m0 handshake, held through 3 stall cycles of ARREADY=0.
REQ-030 SHALL cover: m0 and m1 both valid continuously -> grants alternate m0, m1, m0, m1; downstream ARID[7] alternates 0, 1.
REQ-031 SHALL cover: MAX_OUTSTD=4, m1 issues 4 bursts with no R -> 5th m1 request stalls while m0 is still granted; one m1 RLAST releases it.
REQ-032 SHALL cover: AR handshake and RLAST for m0 in the same cycle at count=2 -> count stays 2.
REQ-033 SHALL cover: RVALID with RID=0x83 while m1 count=0 -> error_fiq=1 and stays 1; m1_RVALID stays 0.
REQ-034 SHALL cover: sys_rst asserted during ISSUE -> ARVALID=0 next cycle, counters=0; with PERF_EN, gnt counters=0.

Source files
------------

// File: rtl/cpucore_axi_pkg.sv
// Shared AXI width constants and the address-channel arbiter state encoding
// for the cpucore read path.
package cpucore_axi_pkg;
  localparam int ADDR_W  = 32;
  localparam int ID_W    = 8;   // downstream ID; MSB carries the master index
  localparam int DATA_W  = 128;
  localparam int LEN_W   = 4;   // ARLEN and ARSIZE width
  localparam int NUM_MST = 2;
  localparam int CNT_W   = 4;   // outstanding counters, MAX_OUTSTD <= 15

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational.
//   req[1:0] : eligible requesters
//   last     : index of the requester granted most recently
//   gnt[1:0] : one-hot grant (zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    // on a tie the requester that did not win last time goes first
    if (&req) gnt = last ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/cpucore_rd_arb.sv
// Read-channel arbiter merging two upstream AXI read masters (m0, m1) onto a
// single downstream port (cpucore_mst_*).
//   AR: round-robin grant in IDLE, upstream ARREADY is combinational for the
//       winner, payload registered and presented downstream during ISSUE.
//       Downstream ARID = {master index, upstream ARID}.
//   R : routed combinationally on cpucore_mst_RID[7]. A beat arriving for a
//       master with nothing outstanding is sunk and raises sticky error_fiq.
//   Per-master outstanding counters block grants at MAX_OUTSTD.
// Optional: define CPUCORE_RD_ARB_PERF_EN to add m0_gnt_cnt / m1_gnt_cnt,
// saturating 16-bit grant counters.
module cpucore_rd_arb
  import cpucore_axi_pkg::*;
#(
  parameter int MAX_OUTSTD = 4
) (
  input  logic                ref_clk,
  input  logic                sys_rst,
  // upstream master 0
  input  logic [ADDR_W-1:0]   m0_ARADDR,
  input  logic [ID_W-2:0]     m0_ARID,
  input  logic [LEN_W-1:0]    m0_ARLEN,
  input  logic [LEN_W-1:0]    m0_ARSIZE,
  input  logic                m0_ARVALID,
  output logic                m0_ARREADY,
  output logic [ID_W-2:0]     m0_RID,
  output logic [DATA_W-1:0]   m0_RDATA,
  output logic [1:0]          m0_RRESP,
  output logic                m0_RLAST,
  output logic                m0_RVALID,
  input  logic                m0_RREADY,
  // upstream master 1
  input  logic [ADDR_W-1:0]   m1_ARADDR,
  input  logic [ID_W-2:0]     m1_ARID,
  input  logic [LEN_W-1:0]    m1_ARLEN,
  input  logic [LEN_W-1:0]    m1_ARSIZE,
  input  logic                m1_ARVALID,
  output logic                m1_ARREADY,
  output logic [ID_W-2:0]     m1_RID,
  output logic [DATA_W-1:0]   m1_RDATA,
  output logic [1:0]          m1_RRESP,
  output logic                m1_RLAST,
  output logic                m1_RVALID,
  input  logic                m1_RREADY,
  // downstream
  output logic [ADDR_W-1:0]   cpucore_mst_ARADDR,
  output logic [ID_W-1:0]     cpucore_mst_ARID,
  output logic [LEN_W-1:0]    cpucore_mst_ARLEN,
  output logic [LEN_W-1:0]    cpucore_mst_ARSIZE,
  output logic                cpucore_mst_ARVALID,
  input  logic                cpucore_mst_ARREADY,
  input  logic [ID_W-1:0]     cpucore_mst_RID,
  input  logic [DATA_W-1:0]   cpucore_mst_RDATA,
  input  logic [1:0]          cpucore_mst_RRESP,
  input  logic                cpucore_mst_RLAST,
  input  logic                cpucore_mst_RVALID,
  output logic                cpucore_mst_RREADY,
  output logic                error_fiq
`ifdef CPUCORE_RD_ARB_PERF_EN
  ,
  output logic [15:0]         m0_gnt_cnt,
  output logic [15:0]         m1_gnt_cnt
`endif
);

  arb_state_e                     state;
  logic                           last_q;
  logic [NUM_MST-1:0][CNT_W-1:0]  out_cnt;
  logic [NUM_MST-1:0]             elig, gnt, inc, dec;
  logic                           r_sel, err_beat;

  // ---------------- AR arbitration ----------------
  always_comb begin
    elig[0] = (state == ST_IDLE) & m0_ARVALID & (out_cnt[0] < CNT_W'(MAX_OUTSTD));
    elig[1] = (state == ST_IDLE) & m1_ARVALID & (out_cnt[1] < CNT_W'(MAX_OUTSTD));
  end

  rr_arb2 u_rr (
    .req  (elig),
    .last (last_q),
    .gnt  (gnt)
  );

  // grant implies ARVALID, so the grant itself is the upstream handshake
  assign m0_ARREADY = gnt[0];
  assign m1_ARREADY = gnt[1];
  assign inc        = gnt;

  always_ff @(posedge ref_clk) begin
    if (sys_rst) begin
      state               <= ST_IDLE;
      last_q              <= 1'b1;
      cpucore_mst_ARVALID <= 1'b0;
      cpucore_mst_ARADDR  <= '0;
      cpucore_mst_ARID    <= '0;
      cpucore_mst_ARLEN   <= '0;
      cpucore_mst_ARSIZE  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|gnt) begin
          state               <= ST_ISSUE;
          last_q              <= gnt[1];
          cpucore_mst_ARVALID <= 1'b1;
          cpucore_mst_ARADDR  <= gnt[1] ? m1_ARADDR : m0_ARADDR;
          cpucore_mst_ARID    <= gnt[1] ? {1'b1, m1_ARID} : {1'b0, m0_ARID};
          cpucore_mst_ARLEN   <= gnt[1] ? m1_ARLEN  : m0_ARLEN;
          cpucore_mst_ARSIZE  <= gnt[1] ? m1_ARSIZE : m0_ARSIZE;
        end
        ST_ISSUE: if (cpucore_mst_ARREADY) begin
          state               <= ST_IDLE;
          cpucore_mst_ARVALID <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- R routing ----------------
  assign r_sel    = cpucore_mst_RID[ID_W-1];
  // a beat for a master with nothing in flight is misrouted: swallow it
  assign err_beat = cpucore_mst_RVALID & (out_cnt[r_sel] == '0);

  assign m0_RID   = cpucore_mst_RID[ID_W-2:0];
  assign m1_RID   = cpucore_mst_RID[ID_W-2:0];
  assign m0_RDATA = cpucore_mst_RDATA;
  assign m1_RDATA = cpucore_mst_RDATA;
  assign m0_RRESP = cpucore_mst_RRESP;
  assign m1_RRESP = cpucore_mst_RRESP;
  assign m0_RLAST = cpucore_mst_RLAST;
  assign m1_RLAST = cpucore_mst_RLAST;

  assign m0_RVALID = cpucore_mst_RVALID & ~r_sel & ~err_beat;
  assign m1_RVALID = cpucore_mst_RVALID &  r_sel & ~err_beat;
  assign cpucore_mst_RREADY = err_beat | (r_sel ? m1_RREADY : m0_RREADY);

  always_comb begin
    for (int i = 0; i < NUM_MST; i++)
      dec[i] = cpucore_mst_RVALID & cpucore_mst_RREADY & cpucore_mst_RLAST &
               ~err_beat & (r_sel == 1'(i));
  end

  // ---------------- outstanding counters / error flag ----------------
  always_ff @(posedge ref_clk) begin
    if (sys_rst) begin
      out_cnt   <= '0;
      error_fiq <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MST; i++) begin
        if (inc[i] & ~dec[i])      out_cnt[i] <= out_cnt[i] + 1'b1;
        else if (dec[i] & ~inc[i]) out_cnt[i] <= out_cnt[i] - 1'b1;
      end
      if (err_beat) error_fiq <= 1'b1;
    end
  end

`ifdef CPUCORE_RD_ARB_PERF_EN
  logic [NUM_MST-1:0][15:0] gnt_cnt_q;

  always_ff @(posedge ref_clk) begin
    if (sys_rst) gnt_cnt_q <= '0;
    else
      for (int i = 0; i < NUM_MST; i++)
        if (gnt[i] && gnt_cnt_q[i] != 16'hFFFF) gnt_cnt_q[i] <= gnt_cnt_q[i] + 16'd1;
  end

  assign m0_gnt_cnt = gnt_cnt_q[0];
  assign m1_gnt_cnt = gnt_cnt_q[1];
`endif

endmodule

// File: tb/tb_cpucore_rd_arb.sv
module tb_cpucore_rd_arb;
  localparam int MAXO = 4;

  logic         ref_clk = 1'b0;
  logic         sys_rst;
  logic [31:0]  m0_ARADDR, m1_ARADDR;
  logic [6:0]   m0_ARID, m1_ARID;
  logic [3:0]   m0_ARLEN, m1_ARLEN, m0_ARSIZE, m1_ARSIZE;
  logic         m0_ARVALID, m1_ARVALID, m0_ARREADY, m1_ARREADY;
  logic [6:0]   m0_RID, m1_RID;
  logic [127:0] m0_RDATA, m1_RDATA;
  logic [1:0]   m0_RRESP, m1_RRESP;
  logic         m0_RLAST, m1_RLAST, m0_RVALID, m1_RVALID, m0_RREADY, m1_RREADY;
  logic [31:0]  mst_ARADDR;
  logic [7:0]   mst_ARID;
  logic [3:0]   mst_ARLEN, mst_ARSIZE;
  logic         mst_ARVALID, mst_ARREADY;
  logic [7:0]   mst_RID;
  logic [127:0] mst_RDATA;
  logic [1:0]   mst_RRESP;
  logic         mst_RLAST, mst_RVALID, mst_RREADY;
  logic         error_fiq;
`ifdef CPUCORE_RD_ARB_PERF_EN
  logic [15:0]  m0_gnt_cnt, m1_gnt_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 ref_clk = ~ref_clk;

  cpucore_rd_arb #(.MAX_OUTSTD(MAXO)) dut (
    .ref_clk(ref_clk), .sys_rst(sys_rst),
    .m0_ARADDR(m0_ARADDR), .m0_ARID(m0_ARID), .m0_ARLEN(m0_ARLEN), .m0_ARSIZE(m0_ARSIZE),
    .m0_ARVALID(m0_ARVALID), .m0_ARREADY(m0_ARREADY),
    .m0_RID(m0_RID), .m0_RDATA(m0_RDATA), .m0_RRESP(m0_RRESP), .m0_RLAST(m0_RLAST),
    .m0_RVALID(m0_RVALID), .m0_RREADY(m0_RREADY),
    .m1_ARADDR(m1_ARADDR), .m1_ARID(m1_ARID), .m1_ARLEN(m1_ARLEN), .m1_ARSIZE(m1_ARSIZE),
    .m1_ARVALID(m1_ARVALID), .m1_ARREADY(m1_ARREADY),
    .m1_RID(m1_RID), .m1_RDATA(m1_RDATA), .m1_RRESP(m1_RRESP), .m1_RLAST(m1_RLAST),
    .m1_RVALID(m1_RVALID), .m1_RREADY(m1_RREADY),
    .cpucore_mst_ARADDR(mst_ARADDR), .cpucore_mst_ARID(mst_ARID),
    .cpucore_mst_ARLEN(mst_ARLEN), .cpucore_mst_ARSIZE(mst_ARSIZE),
    .cpucore_mst_ARVALID(mst_ARVALID), .cpucore_mst_ARREADY(mst_ARREADY),
    .cpucore_mst_RID(mst_RID), .cpucore_mst_RDATA(mst_RDATA), .cpucore_mst_RRESP(mst_RRESP),
    .cpucore_mst_RLAST(mst_RLAST), .cpucore_mst_RVALID(mst_RVALID),
    .cpucore_mst_RREADY(mst_RREADY),
    .error_fiq(error_fiq)
`ifdef CPUCORE_RD_ARB_PERF_EN
    , .m0_gnt_cnt(m0_gnt_cnt), .m1_gnt_cnt(m1_gnt_cnt)
`endif
  );

  task automatic idle_inputs();
    m0_ARVALID = 0; m1_ARVALID = 0;
    m0_ARADDR = '0; m1_ARADDR = '0; m0_ARID = '0; m1_ARID = '0;
    m0_ARLEN = '0; m1_ARLEN = '0; m0_ARSIZE = '0; m1_ARSIZE = '0;
    m0_RREADY = 0; m1_RREADY = 0; mst_ARREADY = 0;
    mst_RID = '0; mst_RDATA = '0; mst_RRESP = '0; mst_RLAST = 0; mst_RVALID = 0;
  endtask

  // ends just after a falling edge with reset released
  task automatic reset_dut();
    idle_inputs();
    sys_rst = 1;
    repeat (2) @(negedge ref_clk);
    sys_rst = 0;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if (mst_ARVALID !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%b exp=0", mst_ARVALID); end
    checks++; if (error_fiq !== 1'b0) begin errors++; $display("FAIL reset_fiq got=%b exp=0", error_fiq); end
    checks++; if ({m1_ARREADY, m0_ARREADY} !== 2'b00) begin errors++; $display("FAIL reset_arready got=%b exp=00", {m1_ARREADY, m0_ARREADY}); end
    checks++; if (dut.out_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got=%h exp=00", dut.out_cnt); end
`ifdef CPUCORE_RD_ARB_PERF_EN
    checks++; if ({m0_gnt_cnt, m1_gnt_cnt} !== 32'h0) begin errors++; $display("FAIL reset_gnt_cnt got=%h exp=0", {m0_gnt_cnt, m1_gnt_cnt}); end
`endif
  endtask

  task automatic test_single();
    reset_dut();
    m0_ARVALID = 1; m0_ARADDR = 32'h1000; m0_ARID = 7'h05; m0_ARLEN = 4'd3; m0_ARSIZE = 4'd4;
    #1;
    checks++; if ({m1_ARREADY, m0_ARREADY} !== 2'b01) begin errors++; $display("FAIL single_grant got=%b exp=01", {m1_ARREADY, m0_ARREADY}); end
    checks++; if (mst_ARVALID !== 1'b0) begin errors++; $display("FAIL single_pre_valid got=%b exp=0", mst_ARVALID); end
    @(negedge ref_clk); m0_ARVALID = 0; #1;
    checks++; if (mst_ARVALID !== 1'b1) begin errors++; $display("FAIL single_latency got=%b exp=1", mst_ARVALID); end
    checks++; if ({mst_ARID, mst_ARADDR, mst_ARLEN, mst_ARSIZE} !== {8'h05, 32'h1000, 4'd3, 4'd4})
      begin errors++; $display("FAIL single_payload got=%h/%h/%h/%h exp=05/00001000/3/4", mst_ARID, mst_ARADDR, mst_ARLEN, mst_ARSIZE); end
    for (int s = 0; s < 3; s++) begin
      m0_ARVALID = 1;  // must not be accepted while ISSUE is stalled
      @(negedge ref_clk); #1;
      checks++; if ({mst_ARVALID, mst_ARID, mst_ARADDR, m0_ARREADY} !== {1'b1, 8'h05, 32'h1000, 1'b0})
        begin errors++; $display("FAIL single_stall%0d got=%b/%h/%h/%b exp=1/05/00001000/0", s, mst_ARVALID, mst_ARID, mst_ARADDR, m0_ARREADY); end
    end
    m0_ARVALID = 0; mst_ARREADY = 1;
    @(negedge ref_clk); mst_ARREADY = 0; #1;
    checks++; if (mst_ARVALID !== 1'b0) begin errors++; $display("FAIL single_release got=%b exp=0", mst_ARVALID); end
    mst_RVALID = 1; mst_RID = 8'h05; mst_RLAST = 1; mst_RDATA = {4{$urandom}}; m0_RREADY = 1; #1;
    checks++; if ({m0_RVALID, m1_RVALID, mst_RREADY, m0_RID} !== {1'b1, 1'b0, 1'b1, 7'h05})
      begin errors++; $display("FAIL single_r got=%b%b%b/%h exp=101/05", m0_RVALID, m1_RVALID, mst_RREADY, m0_RID); end
    checks++; if (m0_RDATA !== mst_RDATA) begin errors++; $display("FAIL single_rdata got=%h exp=%h", m0_RDATA, mst_RDATA); end
    @(negedge ref_clk); idle_inputs(); #1;
    checks++; if (dut.out_cnt[0] !== 4'd0) begin errors++; $display("FAIL single_cnt got=%0d exp=0", dut.out_cnt[0]); end
  endtask

  task automatic test_rr();
    int gi;
    logic exp_q[$];
    reset_dut();
    m0_ARVALID = 1; m0_ARID = 7'h11; m1_ARVALID = 1; m1_ARID = 7'h22; mst_ARREADY = 1;
    gi = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (mst_ARVALID === 1'b1 && exp_q.size() > 0) begin
        checks++; if (mst_ARID[7] !== exp_q[0]) begin errors++; $display("FAIL rr_arid7 got=%b exp=%b", mst_ARID[7], exp_q[0]); end
        void'(exp_q.pop_front());
      end
      if (m0_ARREADY | m1_ARREADY) begin
        checks++; if ({m1_ARREADY, m0_ARREADY} !== ((gi % 2) ? 2'b10 : 2'b01))
          begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", gi, {m1_ARREADY, m0_ARREADY}, (gi % 2) ? 2'b10 : 2'b01); end
        exp_q.push_back(1'((gi % 2)));
        gi++;
      end
      @(negedge ref_clk);
    end
    checks++; if (gi !== 4) begin errors++; $display("FAIL rr_count got=%0d exp=4", gi); end
    idle_inputs();
  endtask

  task automatic test_outstd();
    int g;
    reset_dut();
    m1_ARVALID = 1; mst_ARREADY = 1; g = 0;
    for (int c = 0; c < 8; c++) begin
      #1; if (m1_ARREADY) g++;
      @(negedge ref_clk);
    end
    checks++; if (g !== MAXO) begin errors++; $display("FAIL outstd_fill got=%0d exp=%0d", g, MAXO); end
    #1;
    checks++; if (m1_ARREADY !== 1'b0) begin errors++; $display("FAIL outstd_block got=%b exp=0", m1_ARREADY); end
    m0_ARVALID = 1; #1;
    checks++; if ({m1_ARREADY, m0_ARREADY} !== 2'b01) begin errors++; $display("FAIL outstd_m0_ok got=%b exp=01", {m1_ARREADY, m0_ARREADY}); end
    @(negedge ref_clk);
    mst_RVALID = 1; mst_RID = 8'h80; mst_RLAST = 1; m1_RREADY = 1; #1;
    checks++; if ({m1_RVALID, mst_RREADY} !== 2'b11) begin errors++; $display("FAIL outstd_rlast got=%b exp=11", {m1_RVALID, mst_RREADY}); end
    @(negedge ref_clk); mst_RVALID = 0; mst_RLAST = 0; #1;
    checks++; if ({m1_ARREADY, m0_ARREADY} !== 2'b10) begin errors++; $display("FAIL outstd_release got=%b exp=10", {m1_ARREADY, m0_ARREADY}); end
    @(negedge ref_clk); idle_inputs();
  endtask

  task automatic test_same_cycle();
    reset_dut();
    m0_ARVALID = 1; mst_ARREADY = 1;
    repeat (4) @(negedge ref_clk);
    #1;
    checks++; if (dut.out_cnt[0] !== 4'd2) begin errors++; $display("FAIL same_pre got=%0d exp=2", dut.out_cnt[0]); end
    mst_RVALID = 1; mst_RID = 8'h00; mst_RLAST = 1; m0_RREADY = 1; #1;
    checks++; if ({m0_ARREADY, mst_RREADY} !== 2'b11) begin errors++; $display("FAIL same_hs got=%b exp=11", {m0_ARREADY, mst_RREADY}); end
    @(negedge ref_clk); idle_inputs(); #1;
    checks++; if (dut.out_cnt[0] !== 4'd2) begin errors++; $display("FAIL same_cnt got=%0d exp=2", dut.out_cnt[0]); end
  endtask

  task automatic test_err();
    reset_dut();
    mst_RVALID = 1; mst_RID = 8'h83; mst_RLAST = 1; m1_RREADY = 0; #1;
    checks++; if ({m1_RVALID, m0_RVALID, mst_RREADY} !== 3'b001) begin errors++; $display("FAIL err_sink got=%b exp=001", {m1_RVALID, m0_RVALID, mst_RREADY}); end
    @(negedge ref_clk); idle_inputs(); #1;
    checks++; if (error_fiq !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", error_fiq); end
    repeat (3) @(negedge ref_clk); #1;
    checks++; if (error_fiq !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", error_fiq); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    m0_ARVALID = 1;
    @(negedge ref_clk); m0_ARVALID = 0; #1;
    checks++; if (mst_ARVALID !== 1'b1) begin errors++; $display("FAIL rstmid_issue got=%b exp=1", mst_ARVALID); end
    sys_rst = 1;
    @(negedge ref_clk); #1;
    checks++; if (mst_ARVALID !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", mst_ARVALID); end
    checks++; if (dut.out_cnt !== 8'h00) begin errors++; $display("FAIL rstmid_cnt got=%h exp=00", dut.out_cnt); end
`ifdef CPUCORE_RD_ARB_PERF_EN
    checks++; if ({m0_gnt_cnt, m1_gnt_cnt} !== 32'h0) begin errors++; $display("FAIL rstmid_gnt got=%h exp=0", {m0_gnt_cnt, m1_gnt_cnt}); end
`endif
    sys_rst = 0;
  endtask

  // Reference model: one pending downstream request slot, per-master burst
  // counts, sticky error, and the "other master wins a tie" rule.
  task automatic test_random();
    bit        busy = 0, last = 1, err = 0;
    int        cnt[2] = '{0, 0};
    int        ngnt[2] = '{0, 0};
    bit [7:0]  pid = 0;
    bit [31:0] paddr = 0;
    bit        e0, e1, g0, g1, rs, rerr, rr, d0, d1;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      m0_ARVALID = ($urandom_range(0, 2) != 0); m0_ARID = 7'($urandom); m0_ARADDR = $urandom;
      m1_ARVALID = ($urandom_range(0, 2) != 0); m1_ARID = 7'($urandom); m1_ARADDR = $urandom;
      mst_ARREADY = $urandom_range(0, 1);
      rs = $urandom_range(0, 1);
      mst_RVALID = ($urandom_range(0, 3) == 0) && (cnt[rs] > 0 || $urandom_range(0, 20) == 0);
      mst_RID = {rs, 7'($urandom)}; mst_RLAST = $urandom_range(0, 1); mst_RDATA = {4{$urandom}};
      m0_RREADY = $urandom_range(0, 1); m1_RREADY = $urandom_range(0, 1);
      #1;
      e0 = !busy && m0_ARVALID && cnt[0] < MAXO;
      e1 = !busy && m1_ARVALID && cnt[1] < MAXO;
      g0 = e0 && (!e1 || last == 1);
      g1 = e1 && (!e0 || last == 0);
      rerr = mst_RVALID && cnt[rs] == 0;
      rr = rerr || (rs ? m1_RREADY : m0_RREADY);
      checks++; if ({m1_ARREADY, m0_ARREADY} !== {g1, g0})
        begin errors++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c, {m1_ARREADY, m0_ARREADY}, {g1, g0}); end
      checks++; if (mst_ARVALID !== busy || (busy && {mst_ARID, mst_ARADDR} !== {pid, paddr}))
        begin errors++; $display("FAIL rand_ar c=%0d got=%b/%h/%h exp=%b/%h/%h", c, mst_ARVALID, mst_ARID, mst_ARADDR, busy, pid, paddr); end
      checks++; if ({m1_RVALID, m0_RVALID, mst_RREADY} !== {mst_RVALID && rs && !rerr, mst_RVALID && !rs && !rerr, rr})
        begin errors++; $display("FAIL rand_r c=%0d got=%b exp=%b", c, {m1_RVALID, m0_RVALID, mst_RREADY}, {mst_RVALID && rs && !rerr, mst_RVALID && !rs && !rerr, rr}); end
      checks++; if (error_fiq !== err) begin errors++; $display("FAIL rand_fiq c=%0d got=%b exp=%b", c, error_fiq, err); end
`ifdef CPUCORE_RD_ARB_PERF_EN
      checks++; if (m0_gnt_cnt !== 16'(ngnt[0]) || m1_gnt_cnt !== 16'(ngnt[1]))
        begin errors++; $display("FAIL rand_gnt_cnt c=%0d got=%0d/%0d exp=%0d/%0d", c, m0_gnt_cnt, m1_gnt_cnt, ngnt[0], ngnt[1]); end
`endif
      d0 = mst_RVALID && rr && mst_RLAST && !rerr && !rs;
      d1 = mst_RVALID && rr && mst_RLAST && !rerr && rs;
      cnt[0] = cnt[0] + int'(g0) - int'(d0);
      cnt[1] = cnt[1] + int'(g1) - int'(d1);
      if (rerr) err = 1;
      if (busy && mst_ARREADY) busy = 0;
      if (g0 || g1) begin
        busy = 1; last = g1; ngnt[g1] = ngnt[g1] + 1;
        pid = g1 ? {1'b1, m1_ARID} : {1'b0, m0_ARID};
        paddr = g1 ? m1_ARADDR : m0_ARADDR;
      end
      @(negedge ref_clk);
    end
    idle_inputs();
  endtask

  initial begin
    sys_rst = 1;
    idle_inputs();
    test_reset();
    test_single();
    test_rr();
    test_outstd();
    test_same_cycle();
    test_err();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
